// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared constants, state type and sizing helper for the branch resolve unit
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } bru_state_e;

  // Counter must be able to hold FLUSH_CYCLES itself.
  function automatic int flush_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bru_cond_select.sv
// rtl/bru_cond_select.sv - funct3 driven selection of the ALU comparison flag for conditional branches
module bru_cond_select
  import bru_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       equal,
  input  logic       not_equal,
  input  logic       lesser_than,
  input  logic       greater_or_equal,
  input  logic       unsigned_lesser,
  input  logic       unsigned_greater_equal,
  output logic       cond,
  output logic       illegal
);

  // Pick the flag for this condition code; the two unused encodings are flagged illegal.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = equal;
      F3_BNE:  cond = not_equal;
      F3_BLT:  cond = lesser_than;
      F3_BGE:  cond = greater_or_equal;
      F3_BLTU: cond = unsigned_lesser;
      F3_BGEU: cond = unsigned_greater_equal;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves branches/jumps, issues fetch redirect and timed flush (optional BRU_MISALIGN_CHECK_EN)
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            equal,
  input  logic            not_equal,
  input  logic            lesser_than,
  input  logic            greater_or_equal,
  input  logic            unsigned_lesser,
  input  logic            unsigned_greater_equal,
  output logic            taken,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_branch,
  output logic            misalign_exc
);

  localparam int CNT_W = flush_cnt_w(FLUSH_CYCLES);
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  bru_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            cond;
  logic            cond_illegal;
  logic            taken_raw;
  logic            misaligned;
  logic            taken_ok;
  logic [XLEN-1:0] target;

  bru_cond_select u_cond (
    .funct3                 (funct3),
    .equal                  (equal),
    .not_equal              (not_equal),
    .lesser_than            (lesser_than),
    .greater_or_equal       (greater_or_equal),
    .unsigned_lesser        (unsigned_lesser),
    .unsigned_greater_equal (unsigned_greater_equal),
    .cond                   (cond),
    .illegal                (cond_illegal)
  );

  assign accept    = in_valid & in_ready;
  assign taken_raw = (is_branch & cond) | is_jal | is_jalr;
  // JALR clears bit 0 of the computed address; everything else is pc-relative with wraparound.
  assign target    = is_jalr ? (alu_result & JALR_MASK) : (pc + imm);

`ifdef BRU_MISALIGN_CHECK_EN
  assign misaligned = taken_raw & target[1];
`else
  assign misaligned = 1'b0;
`endif

  assign taken_ok = taken_raw & ~misaligned;

  assign in_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == FLUSH);
  assign redirect_pc    = pc_q;
  assign taken          = taken_q;
  assign illegal_branch = illegal_q;

  // State, flush counter, held target and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pc_q      <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: accept in IDLE, hold the redirect until fetch takes it, then count down the flush.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          taken_d   = taken_ok;
          illegal_d = is_branch & cond_illegal;
          if (taken_ok) begin
            state_d = REDIRECT;
            pc_d    = target;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BRU_MISALIGN_CHECK_EN
  logic mis_q;

  // Misaligned taken target: report once, never redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= accept & misaligned;
    end
  end

  assign misalign_exc = mis_q;
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int XLEN = 64;
  localparam int FC   = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            is_branch, is_jal, is_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc, imm, alu_result;
  logic            equal, not_equal, lesser_than, greater_or_equal;
  logic            unsigned_lesser, unsigned_greater_equal;
  logic            taken;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            illegal_branch;
  logic            misalign_exc;

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .is_branch              (is_branch),
    .is_jal                 (is_jal),
    .is_jalr                (is_jalr),
    .funct3                 (funct3),
    .pc                     (pc),
    .imm                    (imm),
    .alu_result             (alu_result),
    .equal                  (equal),
    .not_equal              (not_equal),
    .lesser_than            (lesser_than),
    .greater_or_equal       (greater_or_equal),
    .unsigned_lesser        (unsigned_lesser),
    .unsigned_greater_equal (unsigned_greater_equal),
    .taken                  (taken),
    .redirect_valid         (redirect_valid),
    .redirect_ready         (redirect_ready),
    .redirect_pc            (redirect_pc),
    .flush                  (flush),
    .illegal_branch         (illegal_branch),
    .misalign_exc           (misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operands stand in for rs1/rs2; the ALU flags are derived from them.
  task automatic set_flags(input logic [63:0] a, input logic [63:0] b);
    equal                  = (a == b);
    not_equal              = (a != b);
    lesser_than            = ($signed(a) < $signed(b));
    greater_or_equal       = ($signed(a) >= $signed(b));
    unsigned_lesser        = (a < b);
    unsigned_greater_equal = (a >= b);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_taken"}, taken, 1'b0);
    check({tag, "_rvalid"}, redirect_valid, 1'b0);
    check({tag, "_rpc"}, redirect_pc, 64'h0);
    check({tag, "_flush"}, flush, 1'b0);
    check({tag, "_illegal"}, illegal_branch, 1'b0);
    check({tag, "_misalign"}, misalign_exc, 1'b0);
  endtask

  // cls: 0 none, 1 branch, 2 jal, 3 jalr. delay = cycles redirect_ready is withheld.
  task automatic run_insn(input string tag, input int cls, input logic [2:0] f3,
                          input logic [63:0] ipc, input logic [63:0] iimm,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] alu, input int delay);
    logic        cond_m, tk, mis, redir, ill;
    logic [63:0] tgt;
    case (f3)
      3'd0:    cond_m = (a == b);
      3'd1:    cond_m = (a != b);
      3'd4:    cond_m = ($signed(a) < $signed(b));
      3'd5:    cond_m = !($signed(a) < $signed(b));
      3'd6:    cond_m = (a < b);
      3'd7:    cond_m = !(a < b);
      default: cond_m = 1'b0;
    endcase
    ill = (cls == 1) && (f3 == 3'd2 || f3 == 3'd3);
    tk  = (cls == 2) || (cls == 3) || ((cls == 1) && cond_m);
    tgt = (cls == 3) ? {alu[63:1], 1'b0} : (ipc + iimm);
`ifdef BRU_MISALIGN_CHECK_EN
    mis = tk && tgt[1];
`else
    mis = 1'b0;
`endif
    redir = tk && !mis;

    check({tag, "_pre_ready"}, in_ready, 1'b1);
    is_branch  = (cls == 1);
    is_jal     = (cls == 2);
    is_jalr    = (cls == 3);
    funct3     = f3;
    pc         = ipc;
    imm        = iimm;
    alu_result = alu;
    set_flags(a, b);
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;

    check({tag, "_taken"}, taken, redir);
    check({tag, "_illegal"}, illegal_branch, ill);
    check({tag, "_misalign"}, misalign_exc, mis);
    check({tag, "_rvalid"}, redirect_valid, redir);
    check({tag, "_in_ready"}, in_ready, !redir);
    if (redir) begin
      check({tag, "_rpc"}, redirect_pc, tgt);
      repeat (delay) begin
        tick();
        check({tag, "_hold_rvalid"}, redirect_valid, 1'b1);
        check({tag, "_hold_rpc"}, redirect_pc, tgt);
        check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        check({tag, "_hold_flush"}, flush, 1'b0);
        check({tag, "_hold_taken"}, taken, 1'b0);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      for (int i = 0; i < FC; i++) begin
        check({tag, "_flush"}, flush, 1'b1);
        check({tag, "_flush_rvalid"}, redirect_valid, 1'b0);
        check({tag, "_flush_in_ready"}, in_ready, 1'b0);
        check({tag, "_flush_taken"}, taken, 1'b0);
        tick();
      end
      check({tag, "_end_flush"}, flush, 1'b0);
      check({tag, "_end_in_ready"}, in_ready, 1'b1);
    end else begin
      tick();
      check({tag, "_after_in_ready"}, in_ready, 1'b1);
      check({tag, "_after_flush"}, flush, 1'b0);
      check({tag, "_after_illegal"}, illegal_branch, 1'b0);
      check({tag, "_after_misalign"}, misalign_exc, 1'b0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    is_branch      = 1'b0;
    is_jal         = 1'b0;
    is_jalr        = 1'b0;
    funct3         = 3'd0;
    pc             = '0;
    imm            = '0;
    alu_result     = '0;
    redirect_ready = 1'b0;
    set_flags(64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check_all_reset("reset");
    #3 rst_n = 1'b1;
    tick();
    check_all_reset("post_reset");

    // BEQ taken, immediate handshake
    run_insn("beq", 1, 3'd0, 64'h1000, 64'h20, 64'd5, 64'd5, 64'h0, 0);

    // BLTU not taken, three back-to-back accepts
    is_branch = 1'b1;
    funct3    = 3'd6;
    pc        = 64'h3000;
    imm       = 64'h40;
    set_flags(64'd10, 64'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bltu_b2b_ready_pre", in_ready, 1'b1);
      tick();
      check("bltu_b2b_taken", taken, 1'b0);
      check("bltu_b2b_rvalid", redirect_valid, 1'b0);
      check("bltu_b2b_ready", in_ready, 1'b1);
    end
    in_valid  = 1'b0;
    is_branch = 1'b0;

    // JALR with odd address
    run_insn("jalr", 3, 3'd0, 64'h500, 64'h0, 64'd0, 64'd0, 64'h2003, 0);

    // Taken BNE with redirect_ready withheld five cycles
    run_insn("bne_hold", 1, 3'd1, 64'h4000, 64'hFFFF_FFFF_FFFF_FF00, 64'd1, 64'd2, 64'h0, 5);

    // Illegal branch encoding
    run_insn("illegal", 1, 3'd2, 64'h4000, 64'h10, 64'd1, 64'd1, 64'h0, 0);

    // Non control-transfer accept
    run_insn("nop", 0, 3'd0, 64'h4000, 64'h10, 64'd1, 64'd1, 64'h0, 0);

    // redirect_ready in IDLE is ignored
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("stray_ready_in_ready", in_ready, 1'b1);
    check("stray_ready_flush", flush, 1'b0);
    tick();
    check("stray_ready_flush2", flush, 1'b0);

    // JAL wrapping past 2^64
    run_insn("jal_wrap", 2, 3'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0, 64'd0, 64'h0, 0);

    // Asynchronous reset during FLUSH
    is_jal   = 1'b1;
    pc       = 64'h8000;
    imm      = 64'h100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    is_jal   = 1'b0;
    check("rst_flush_rvalid", redirect_valid, 1'b1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("rst_flush_active", flush, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_reset("rst_mid_flush");
    #2 rst_n = 1'b1;
    tick();
    check_all_reset("rst_mid_flush_after");

    // Randomized instructions against the model
    for (int k = 0; k < 40; k++) begin
      int          cls;
      logic [2:0]  f3;
      logic [63:0] ra, rb, rpc, rimm, ralu;
      cls  = $urandom_range(0, 3);
      f3   = 3'($urandom_range(0, 7));
      ra   = {$urandom, $urandom};
      rb   = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      rpc  = {$urandom, $urandom};
      rimm = {$urandom, $urandom};
      ralu = {$urandom, $urandom};
      run_insn("rand", cls, f3, rpc, rimm, ra, rb, ralu, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Stage directly downstream of the 64-bit ALU. Consumes the ALU comparison flags (computed in subtract mode) together with the decoded branch/jump fields, then decides taken/not-taken and computes the target PC. It issues a redirect to fetch over a valid/ready handshake and drives a timed pipeline flush. It accepts at most one control-transfer instruction at a time and back-pressures the issue stage while a redirect is outstanding.

## Interface
Parameters:
- XLEN, 64, datapath and PC width
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect handshake (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept
- is_branch / is_jal / is_jalr  in  1 each  one-hot instruction class (all 0 = not control transfer)
- funct3  in  3  branch condition code
- pc  in  XLEN  instruction PC
- imm  in  XLEN  sign-extended immediate
- alu_result  in  XLEN  rs1+imm for JALR
- equal, not_equal, lesser_than, greater_or_equal, unsigned_lesser, unsigned_greater_equal  in  1 each  ALU flags
- taken  out  1  one-cycle pulse: accepted instruction transfers control
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  XLEN  target, stable while redirect_valid
- flush  out  1  kill younger instructions
- illegal_branch  out  1  one-cycle pulse: funct3 010/011 on a branch
- misalign_exc  out  1  one-cycle pulse (see Configuration)

## Operation
- Accept on rising edge with in_valid && in_ready.
- Condition (branch only): 000 equal, 001 not_equal, 100 lesser_than, 101 greater_or_equal, 110 unsigned_lesser, 111 unsigned_greater_equal; 010/011 → not taken, illegal_branch pulse.
- JAL, JALR: always taken.
- Target: branch/JAL = pc + imm, modulo 2^XLEN (carry discarded); JALR = alu_result with bit 0 cleared.
- Accepted instruction with all class bits 0: no effect beyond acceptance.
- FSM:
  - IDLE: in_ready=1. A taken accept → REDIRECT. Not taken → stay in IDLE.
  - REDIRECT: in_ready=0, redirect_valid=1. redirect_pc is held. Handshake → FLUSH, counter loaded with FLUSH_CYCLES.
  - FLUSH: in_ready=0, flush=1. Counter decrements each cycle; at 1 → IDLE.
- Reset values: state IDLE, in_ready=1, all other outputs 0, redirect_pc 0. Asynchronous reset mid-REDIRECT/FLUSH aborts immediately with no redirect.

## Timing
- Accept at edge N → taken, illegal_branch and misalign_exc pulse in cycle N+1. redirect_valid rises in N+1. All outputs are registered.
- redirect_ready high in N+1 → handshake at edge N+1. flush is high for cycles N+2 … N+1+FLUSH_CYCLES. in_ready returns high in cycle N+2+FLUSH_CYCLES.
- redirect_ready low: redirect_valid and redirect_pc are held indefinitely.
- redirect_ready while redirect_valid=0: ignored.
- Not-taken branch: in_ready stays 1, so back-to-back accepts are allowed every cycle.

## Configuration
- BRU_MISALIGN_CHECK_EN defined: a taken target with bit 1 set is not redirected. The unit pulses misalign_exc and taken=0, then stays in IDLE.
- Undefined: no alignment check; misalign_exc is tied 0.

## Structure
- Package bru_pkg:
  - funct3 constants: F3_BEQ … F3_BGEU
  - state enum: IDLE / REDIRECT / FLUSH
  - flush counter width: $clog2(FLUSH_CYCLES+1)
- Sub-module bru_cond_select: combinational funct3 → flag mux with illegal output. It is unit-testable alone.

## Test plan
- BEQ, equal=1, pc=0x1000, imm=0x20, redirect_ready=1:
  - taken pulse in N+1, redirect_pc=0x1020.
  - flush high for 2 cycles.
  - in_ready back in N+4.
- BLTU, unsigned_lesser=0, three back-to-back accepts → taken never high, redirect_valid never high, in_ready constantly 1.
- JALR, alu_result=0x2003 → redirect_pc=0x2002. With the macro: misalign_exc=1, no redirect. Without the macro: redirect to 0x2002.
- Taken branch with redirect_ready held low 5 cycles → redirect_valid and redirect_pc stable, in_ready=0 throughout, flush only after the handshake.
- Branch funct3=010 → illegal_branch pulse, taken=0, state remains IDLE.
- JAL pc=0xFFFF_FFFF_FFFF_FFF0, imm=0x20 → redirect_pc=0x10 (wrap). Assert rst_n low during FLUSH → outputs return to reset values immediately.
